// File: rtl/pjw_hash_stream.sv
// Streaming PJW/ELF hash: folds a multi-word byte stream (MSB byte first) one byte
// per cycle behind a Valid/Ready word input and an OutValid/OutReady result output.
module pjw_hash_stream #(
    parameter int DATA_W = 32,
    parameter int HASH_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int BC_W  = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid,
    input  logic              Last,
    input  logic [BC_W-1:0]   ByteCnt,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Ready,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [HASH_W-1:0] DataOut,
    output logic              Busy
);
    localparam int CW = $clog2(NB + 1);
    localparam int S  = HASH_W / 8;
    localparam int F  = 3 * HASH_W / 4;
    localparam logic [HASH_W-1:0] TOP_MASK = {{S{1'b1}}, {(HASH_W - S){1'b0}}};
    localparam logic [CW-1:0]     NB_C     = CW'(NB);

    typedef enum logic [1:0] {IDLE, HASH, OUT} state_t;

    state_t              state_reg, state_next;
    logic [HASH_W-1:0]   hash_reg, hash_next;
    logic [DATA_W-1:0]   word_reg, word_next;
    logic                last_reg, last_next;
    logic [CW-1:0]       nb_reg, nb_next;
    logic [CW-1:0]       idx_reg, idx_next;
    logic [HASH_W-1:0]   dout_reg, dout_next;
    logic                busy_reg, busy_next;

    logic [HASH_W-1:0]   sum, top_bits, step_hash;
    logic [CW-1:0]       bc_ext;

    // The current byte always sits at the top of word_reg; the word shifts left as bytes are consumed.
    always_comb begin
        sum       = (hash_reg << S) + HASH_W'(word_reg[DATA_W-1 -: 8]);
        top_bits  = sum & TOP_MASK;
        step_hash = sum;
        if (top_bits != '0)
            step_hash = step_hash ^ (top_bits >> F);
        step_hash = step_hash & ~top_bits;
    end

    assign bc_ext = CW'(ByteCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            hash_reg  <= '0;
            word_reg  <= '0;
            last_reg  <= 1'b0;
            nb_reg    <= '0;
            idx_reg   <= '0;
            dout_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hash_reg  <= hash_next;
            word_reg  <= word_next;
            last_reg  <= last_next;
            nb_reg    <= nb_next;
            idx_reg   <= idx_next;
            dout_reg  <= dout_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hash_next  = hash_reg;
        word_next  = word_reg;
        last_next  = last_reg;
        nb_next    = nb_reg;
        idx_next   = idx_reg;
        dout_next  = dout_reg;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                if (Valid) begin
                    word_next  = DataIn;
                    last_next  = Last;
                    // Out-of-range counts fall back to a full word.
                    nb_next    = (Last && bc_ext != '0 && bc_ext < NB_C) ? bc_ext : NB_C;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    state_next = HASH;
                end
            end
            HASH: begin
                hash_next = step_hash;
                word_next = word_reg << 8;
                idx_next  = idx_reg + CW'(1);
                if (idx_reg + CW'(1) == nb_reg) begin
                    if (last_reg) begin
                        dout_next  = step_hash;
                        state_next = OUT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            OUT: begin
                if (OutReady) begin
                    hash_next  = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Ready    = (state_reg == IDLE);
    assign OutValid = (state_reg == OUT);
    assign DataOut  = dout_reg;
    assign Busy     = busy_reg;
endmodule

// File: tb/tb_pjw_hash_stream.sv
// Testbench for pjw_hash_stream: vector table, reset/back-pressure/back-to-back
// sequences and randomized messages against a byte-level PJW model.
module tb_pjw_hash_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Valid = 1'b0;
    logic        Last = 1'b0;
    logic [1:0]  ByteCnt = '0;
    logic [31:0] DataIn = '0;
    logic        Ready;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] DataOut;
    logic        Busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;

    pjw_hash_stream #(.DATA_W(32), .HASH_W(32)) dut (
        .clk(clk), .rst(rst), .Valid(Valid), .Last(Last), .ByteCnt(ByteCnt),
        .DataIn(DataIn), .Ready(Ready), .OutValid(OutValid), .OutReady(OutReady),
        .DataOut(DataOut), .Busy(Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        logic [1:0]  bc;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: spec byte rule applied to a plain byte list.
    function automatic logic [31:0] ref_hash(input byte unsigned bq[$]);
        logic [31:0] h, x;
        h = 32'h0;
        foreach (bq[i]) begin
            h = (h << 4) + {24'h0, bq[i]};
            x = h & 32'hF000_0000;
            if (x != 32'h0) h = h ^ (x >> 24);
            h = h & ~x;
        end
        return h;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] bc);
        int n;
        n = 0;
        @(negedge clk);
        Valid = 1'b1; DataIn = d; Last = l; ByteCnt = bc;
        while (!Ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!Ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        Valid = 1'b0;
    endtask

    task automatic run_msg(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int nw, input logic [1:0] bc,
                           input logic [31:0] exp, input int hold);
        logic [31:0] ws[3];
        logic [31:0] got;
        int n, lat, ready_hi, nb;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        for (int i = 0; i < nw; i++)
            send_word(ws[i], (i == nw - 1), (i == nw - 1) ? bc : 2'($urandom));
        nb = (bc == 2'd0) ? 4 : int'(bc);
        n = 0; ready_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (Ready) ready_hi++;
        end while (!OutValid && n < 200);
        lat = cyc - acc_cyc;
        got = DataOut;
        chk({tag, "_outvalid"}, OutValid, 1'b1);
        chk({tag, "_latency"}, lat, nb);
        chk({tag, "_ready_low"}, ready_hi, 0);
        chk({tag, "_data"}, got, exp);
        for (int k = 0; k < hold; k++) begin
            Valid = k[0]; DataIn = 32'hDEAD_BEEF; Last = 1'b1; ByteCnt = 2'd0;
            @(negedge clk);
            chk({tag, "_bp_outvalid"}, OutValid, 1'b1);
            chk({tag, "_bp_stable"}, DataOut, got);
            chk({tag, "_bp_ready"}, Ready, 1'b0);
        end
        Valid = 1'b0;
        OutReady = 1'b1;
        @(posedge clk);
        #1;
        OutReady = 1'b0;
        chk({tag, "_hs_outvalid"}, OutValid, 1'b0);
        chk({tag, "_hs_ready"}, Ready, 1'b1);
        chk({tag, "_hs_busy"}, Busy, 1'b0);
        chk({tag, "_hs_dout_kept"}, DataOut, got);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [31:0] m[3];
        logic [1:0]  mb[3];
        logic [31:0] mexp[3];
        logic [31:0] got[3];
        int nres, pi, busy_low;
        logic acc_now;

        tbl[0] = '{w0: 32'h4142_4344, w1: 32'h0,         nw: 1, bc: 2'd0, exp: 32'h0004_5674};
        tbl[1] = '{w0: 32'h4142_4344, w1: 32'h4546_4748, nw: 2, bc: 2'd0, exp: 32'h0678_9EE8};
        tbl[2] = '{w0: 32'h4142_FFFF, w1: 32'h0,         nw: 1, bc: 2'd2, exp: 32'h0000_0452};
        tbl[3] = '{w0: 32'h41FF_FFFF, w1: 32'h0,         nw: 1, bc: 2'd1, exp: 32'h0000_0041};
        tbl[4] = '{w0: 32'h4142_4344, w1: 32'h4142_FFFF, nw: 2, bc: 2'd2, exp: 32'h0456_7852};

        // Reset state with no clock edge yet.
        #1;
        chk("rst_ready", Ready, 1'b1);
        chk("rst_outvalid", OutValid, 1'b0);
        chk("rst_dataout", DataOut, 32'h0);
        chk("rst_busy", Busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++)
            run_msg($sformatf("vec%0d", i), tbl[i].w0, tbl[i].w1, 32'h0, tbl[i].nw, tbl[i].bc,
                    tbl[i].exp, 0);

        // Reset in the middle of a message drops everything immediately.
        send_word(32'h4142_4344, 1'b0, 2'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_ready", Ready, 1'b1);
        chk("midrst_outvalid", OutValid, 1'b0);
        chk("midrst_dataout", DataOut, 32'h0);
        chk("midrst_busy", Busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_msg("after_rst", 32'h4142_4344, 32'h0, 32'h0, 1, 2'd0, 32'h0004_5674, 0);

        // Back-pressure, ignored Valid pulses, then proof the hash was cleared.
        run_msg("bp", 32'h4546_4748, 32'h0, 32'h0, 1, 2'd0, ref_hash('{8'h45, 8'h46, 8'h47, 8'h48}), 10);
        run_msg("bp_next", 32'h4142_4344, 32'h0, 32'h0, 1, 2'd0, 32'h0004_5674, 0);

        // Back-to-back messages, Valid and OutReady held high.
        m[0] = 32'h4142_4344; mb[0] = 2'd0; mexp[0] = 32'h0004_5674;
        m[1] = 32'h4142_FFFF; mb[1] = 2'd2; mexp[1] = 32'h0000_0452;
        m[2] = 32'h0000_0041; mb[2] = 2'd0; mexp[2] = 32'h0000_0041;
        nres = 0; pi = 0; busy_low = 0;
        @(negedge clk);
        OutReady = 1'b1; Valid = 1'b1; Last = 1'b1; DataIn = m[0]; ByteCnt = mb[0];
        for (int c = 0; c < 100 && nres < 3; c++) begin
            acc_now = Ready && Valid;
            if (OutValid) begin
                chk("b2b_no_accept_in_hs", Ready, 1'b0);
                got[nres] = DataOut;
                nres++;
            end else if (nres >= 1 && nres < 3 && !Busy) begin
                busy_low++;
            end
            @(negedge clk);
            if (acc_now) begin
                pi++;
                if (pi < 3) begin
                    DataIn = m[pi]; ByteCnt = mb[pi];
                end else begin
                    Valid = 1'b0;
                end
            end
        end
        Valid = 1'b0;
        OutReady = 1'b0;
        chk("b2b_results", nres, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_data%0d", i), (i < nres) ? got[i] : 32'hX, mexp[i]);
        chk("b2b_busy_gaps", busy_low, 2);

        // Random messages against the reference model.
        for (int t = 0; t < 25; t++) begin
            logic [31:0] w[3];
            logic [1:0] bc;
            int nw, nbl;
            byte unsigned q[$];
            q = {};
            nw = $urandom_range(1, 3);
            bc = 2'($urandom);
            for (int i = 0; i < 3; i++) w[i] = $urandom;
            for (int i = 0; i < nw; i++) begin
                nbl = (i == nw - 1 && bc != 2'd0) ? int'(bc) : 4;
                for (int b = 0; b < nbl; b++) q.push_back(w[i][31 - 8 * b -: 8]);
            end
            run_msg($sformatf("rnd%0d", t), w[0], w[1], w[2], nw, bc, ref_hash(q),
                    $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
